// File: rtl/ifetch_queue.sv
// Instruction fetch stage: owns the PC and buffers {pc, insn} pairs for decode.
// Optional perf counters (stall_cycles, flush_count) under IFETCH_PERF_CNT_EN.
module ifetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     stall,
  input  logic                     br_taken,
  input  logic [ADDR_W-1:0]        br_target,
  output logic                     if_valid,
  output logic [31:0]              if_instruction,
  output logic [ADDR_W-1:0]        if_pc,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flush_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [31:0]       ins_mem_q [DEPTH];
  logic              enq, deq;

  assign if_valid  = (count_q != '0);
  assign deq       = if_valid & ~stall & ~br_taken;
  assign enq       = ~br_taken & ((count_q < CW'(DEPTH)) | deq);
  assign imem_addr = pc_q;
  assign q_count   = count_q;

  assign if_instruction = if_valid ? ins_mem_q[rd_ptr_q] : '0;
  assign if_pc          = if_valid ? pc_mem_q[rd_ptr_q]  : '0;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (br_taken) begin
      // Redirect flushes the queue; the in-flight word is dropped.
      pc_d     = br_target & ~ADDR_W'(3);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        pc_d     = pc_q + ADDR_W'(4);
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({enq, deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enq) begin
      pc_mem_q[wr_ptr_q]  <= pc_q;
      ins_mem_q[wr_ptr_q] <= imem_data;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (if_valid && stall && !br_taken && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (br_taken && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed testbench for ifetch_queue (DEPTH=4, ADDR_W=64).
// Instruction memory model returns address>>2.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        br_taken;
  logic [63:0] br_target;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [63:0] if_pc;
  logic [2:0]  q_count;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign imem_data = 32'(imem_addr >> 2);

  ifetch_queue #(.DEPTH(4), .ADDR_W(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .q_count        (q_count)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    tick(); tick();
    chk("rst_count", 64'(q_count), 64'd0);
    chk("rst_valid", 64'(if_valid), 64'd0);
    chk("rst_addr", imem_addr, 64'd0);
    chk("rst_pc", if_pc, 64'd0);
    chk("rst_insn", 64'(if_instruction), 64'd0);

    // Free-running fetch
    rst = 1'b0;
    chk("c0_addr", imem_addr, 64'd0);
    chk("c0_valid", 64'(if_valid), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("run_valid", 64'(if_valid), 64'd1);
      chk("run_pc", if_pc, 64'(4 * i));
      chk("run_insn", 64'(if_instruction), 64'(i));
      chk("run_count", 64'(q_count), 64'd1);
    end
    chk("run_addr", imem_addr, 64'd16);

    // Fill under stall
    rst = 1'b1; tick();
    rst = 1'b0; stall = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("full_count", 64'(q_count), 64'd4);
    chk("full_addr", imem_addr, 64'd16);
    chk("full_head", if_pc, 64'd0);

    // Release: full queue enqueues and dequeues together
    stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_pc", if_pc, 64'(4 * i));
      chk("drain_insn", 64'(if_instruction), 64'(i));
      chk("drain_count", 64'(q_count), 64'd4);
      chk("drain_addr", imem_addr, 64'(16 + 4 * i));
    end

    // Redirect while full and stalled
    stall = 1'b1; tick();
    chk("pre_br_count", 64'(q_count), 64'd4);
    br_taken = 1'b1; br_target = 64'h103;
    tick();
    br_taken = 1'b0;
    chk("br_count", 64'(q_count), 64'd0);
    chk("br_valid", 64'(if_valid), 64'd0);
    chk("br_addr", imem_addr, 64'h100);
    chk("br_pc_empty", if_pc, 64'd0);
    tick();
    chk("br_valid2", 64'(if_valid), 64'd1);
    chk("br_pc", if_pc, 64'h100);
    chk("br_insn", 64'(if_instruction), 64'h40);

    // PC wrap-around
    stall = 1'b0; br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    br_taken = 1'b0;
    chk("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_pc0", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_insn0", 64'(if_instruction), 64'hFFFF_FFFF);
    chk("wrap_addr1", imem_addr, 64'd0);
    tick();
    chk("wrap_pc1", if_pc, 64'd0);
    chk("wrap_insn1", 64'(if_instruction), 64'd0);
    chk("wrap_addr2", imem_addr, 64'd4);

    // Reset mid-operation with 3 entries
    rst = 1'b1; tick();
    rst = 1'b0; stall = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_count", 64'(q_count), 64'd3);
    rst = 1'b1; tick();
    rst = 1'b0;
    chk("mid_rst_count", 64'(q_count), 64'd0);
    chk("mid_rst_valid", 64'(if_valid), 64'd0);
    chk("mid_rst_addr", imem_addr, 64'd0);

`ifdef IFETCH_PERF_CNT_EN
    rst = 1'b1; tick();
    chk("perf_rst_stall", 64'(stall_cycles), 64'd0);
    chk("perf_rst_flush", 64'(flush_count), 64'd0);
    rst = 1'b0; stall = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    stall = 1'b0; br_taken = 1'b1; br_target = 64'h200;
    tick(); tick();
    br_taken = 1'b0;
    chk("perf_stall", 64'(stall_cycles), 64'd5);
    chk("perf_flush", 64'(flush_count), 64'd2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction-fetch stage of the pipelined CPU; it feeds the REG/DEC stage.
- Owns the program counter and drives the instruction memory address.
- Buffers fetched {pc, instruction} pairs in a small FIFO, so decode stalls do not lose fetches.
- Accepts a branch redirect from decode (accelerated branching): the queue is flushed and fetch restarts at the target.

Parameters:
- DEPTH, 4: number of queue entries; must be a power of 2 and at least 2.
- ADDR_W, 64: PC and instruction address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- imem_addr  out  ADDR_W  instruction memory address; equals the current PC.
- imem_data  in  32  instruction word for imem_addr, valid in the same cycle (combinational read).
- stall  in  1  decode cannot accept the head entry this cycle.
- br_taken  in  1  redirect request from decode.
- br_target  in  ADDR_W  redirect address; sampled only when br_taken=1.
- if_valid  out  1  head entry present (count != 0).
- if_instruction  out  32  instruction at the queue head.
- if_pc  out  ADDR_W  PC of the head instruction.
- q_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (synchronous, rst=1 at the edge):
  - pc=0, rd_ptr=wr_ptr=0, count=0.
  - if_valid=0, if_instruction=0, if_pc=0, q_count=0, imem_addr=0.
  - Reset asserted mid-operation discards all queue contents and overrides every other input.
- Dequeue (deq):
  - deq = if_valid & ~stall & ~br_taken.
  - rd_ptr advances by 1 (mod DEPTH) when deq=1.
- Enqueue (enq):
  - enq = ~br_taken & (count < DEPTH | deq).
  - When full, a same-cycle dequeue permits enqueue.
  - On enq: mem[wr_ptr] <= {pc, imem_data}; wr_ptr advances by 1 (mod DEPTH); pc <= pc + 4.
  - On no enq: pc holds.
- Count update:
  - count += enq - deq.
  - Never exceeds DEPTH; never underflows.
- Head outputs:
  - if_instruction and if_pc read combinationally from mem[rd_ptr].
  - When count=0, if_instruction and if_pc are driven to 0.
- Latency: an instruction fetched at edge N is visible at the head after edge N when the queue was empty, i.e. 1 cycle address-to-decode.
  - After rst deasserts: cycle 0 presents imem_addr=0; at the following edge pc 0 is enqueued; if_valid=1 with if_pc=0 from then on.
- Redirect (br_taken=1 at an edge):
  - count, rd_ptr, wr_ptr <= 0.
  - pc <= {br_target[ADDR_W-1:2], 2'b00}; low 2 bits are forced to 0.
  - No enqueue or dequeue that cycle; the instruction in flight at imem_data is dropped.
  - Next cycle: imem_addr=target, if_valid=0. One cycle later: if_valid=1 with if_pc=target.
  - br_taken takes priority over stall and over a full queue.
- Wrap-around:
  - pc + 4 wraps modulo 2^ADDR_W with no flag.
  - Pointers wrap modulo DEPTH.
- Full: count=DEPTH with stall=1 holds pc and imem_addr constant; no entry is overwritten.
- Empty: if_valid=0; stall is ignored.

Optional Feature:
- Macro: IFETCH_PERF_CNT_EN.
- When defined, two extra outputs are added:
  - stall_cycles (32-bit): increments on each cycle with if_valid & stall & ~br_taken.
  - flush_count (32-bit): increments on each br_taken cycle.
  - Both clear on rst and saturate at all-ones.
- When undefined: these ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, then stall=0, no branches, memory word = address>>2 -> if_pc sequence 0, 4, 8, 12…; if_instruction 0, 1, 2, 3; if_valid=1 from the second cycle after reset deassert.
- Hold stall=1 for 10 cycles (DEPTH=4) -> q_count reaches 4, imem_addr frozen at 16, head stays pc=0; release stall -> pcs 0, 4, 8, 12, 16 delivered in order with no gaps or duplicates.
- Queue full with stall=0 -> enq and deq in the same cycle; q_count stays 4; pc advances 4 per cycle.
- br_taken=1, br_target=0x103, during stall=1 with queue full -> next cycle q_count=0, if_valid=0, imem_addr=0x100; following cycle if_pc=0x100.
- pc=0xFFFF_FFFF_FFFF_FFFC, stall=0 -> next fetch address is 0; queue order is preserved.
- rst=1 asserted with 3 entries queued -> next cycle q_count=0, if_valid=0, imem_addr=0. With IFETCH_PERF_CNT_EN defined: 5 stalled valid cycles plus 2 branches -> stall_cycles=5, flush_count=2.
